// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller driving an external gate-level full-adder cell, LSB first.
// Optional subtract mode (a - b via ~b plus carry-in 1) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert b and force the initial carry to 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub | cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // busy mirrors state == RUN, so the cell sees zeros whenever we are not streaming.
    assign fa_a   = busy & a_sh[0];
    assign fa_b   = busy & b_sh[0];
    assign fa_cin = busy & carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Only WIDTH-1 sum bits are stored; the final bit goes straight into sum.
                    s_sh  <= (s_sh >> 1) | ((WIDTH-1)'(fa_sum) << (WIDTH - 2));
                    carry <= fa_carry;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {fa_sum, s_sh};
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a delayed behavioural full-adder cell.
// Results are predicted with plain integer arithmetic; define SERIAL_ADD_SUB_EN to cover subtract mode.
module tb_serial_adder_ctrl;

    localparam int W      = 8;
    localparam int PERIOD = 100;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         fa_a, fa_b, fa_cin;
    logic         fa_sum, fa_carry;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    always #(PERIOD/2) clk = ~clk;

    // Full-adder cell with a 40-unit propagation delay, well inside the clock period.
    assign #40 fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign #40 fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    int checks = 0;
    int passes = 0;

    // Current operation as seen by the model, and the result the DUT should be holding.
    logic [W-1:0] op_a, op_b;
    logic         op_c, op_s;
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    time          last_done_t = 0;
    time          prev_done_t = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] eff_b();
        return op_s ? ~op_b : op_b;
    endfunction

    function automatic logic eff_c();
        return op_s ? 1'b1 : op_c;
    endfunction

    function automatic logic [W:0] ref_result();
        return {1'b0, op_a} + {1'b0, eff_b()} + {{W{1'b0}}, eff_c()};
    endfunction

    // Carry entering bit i = bit i of the sum of the lower i bits of both operands plus carry-in.
    function automatic logic ref_carry_in(input int i);
        int unsigned m, s;
        m = (32'd1 << i) - 1;
        s = (int'(op_a) & m) + (int'(eff_b()) & m) + int'(eff_c());
        return s[i];
    endfunction

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        op_a = ta; op_b = tb; op_c = tc; op_s = HAS_SUB ? ts : 1'b0;
        a = ta; b = tb; cin = tc;
`ifdef SERIAL_ADD_SUB_EN
        sub = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble operands: the DUT must not resample them.
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'($urandom);
`endif
    endtask

    // Walk the RUN cycles and the done cycle; abort_at >= 0 pulls reset instead of finishing.
    task automatic stream(input int inject, input int abort_at);
        logic [W:0] r;
        logic [W-1:0] bo;
        bo = eff_b();
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check_val("busy_run", busy, 1);
            check_val("done_run", done, 0);
            check_val("fa_a", fa_a, op_a[i]);
            check_val("fa_b", fa_b, bo[i]);
            check_val("fa_cin", fa_cin, ref_carry_in(i));
            if (i == 0) begin
                check_val("sum_hold", sum, exp_sum);
                check_val("cout_hold", cout, exp_cout);
            end
            start = (i == inject);
            if (i == inject) a = 8'hFF;
            if (i == abort_at) begin
                rst_n = 1'b0;
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        r = ref_result();
        check_val("done_pulse", done, 1);
        check_val("busy_done", busy, 0);
        check_val("sum", sum, r[W-1:0]);
        check_val("cout", cout, r[W]);
        check_val("fa_idle", {fa_a, fa_b, fa_cin}, 0);
        exp_sum = r[W-1:0];
        exp_cout = r[W];
        prev_done_t = last_done_t;
        last_done_t = $time;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_val("done_once", done, 0);
        check_val("busy_idle", busy, 0);
        check_val("sum_idle", sum, exp_sum);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts, input int inject);
        launch(ta, tb, tc, ts);
        stream(inject, -1);
        idle_check();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_sum", sum, 0);
        check_val("rst_cout", cout, 0);
        check_val("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        rst_n = 1'b1;
        idle_check();

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, -1);
        check_val("t1_sum", sum, 8'h10);
        check_val("t1_cout", cout, 0);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        check_val("t2a_sum", sum, 8'h00);
        check_val("t2a_cout", cout, 1);
        run_op(8'hAA, 8'h55, 1'b1, 1'b0, -1);
        check_val("t2b_sum", sum, 8'h00);
        check_val("t2b_cout", cout, 1);

        // Start during RUN must be ignored.
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 2);
        check_val("t3_sum", sum, 8'h46);
        check_val("t3_cout", cout, 0);

        // Reset sampled at the 4th RUN edge aborts the operation.
        launch(8'h80, 8'h80, 1'b0, 1'b0);
        stream(-1, 3);
        @(negedge clk);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_sum", sum, 0);
        check_val("abort_cout", cout, 0);
        check_val("abort_fa", {fa_a, fa_b, fa_cin}, 0);
        exp_sum = '0; exp_cout = 1'b0;
        rst_n = 1'b1;
        idle_check();
        run_op(8'h80, 8'h80, 1'b0, 1'b0, -1);
        check_val("t4_sum", sum, 8'h00);
        check_val("t4_cout", cout, 1);

        // Back-to-back: second start issued in the done cycle.
        launch(8'h33, 8'h44, 1'b0, 1'b0);
        stream(-1, -1);
        launch(8'h01, 8'h02, 1'b0, 1'b0);
        stream(-1, -1);
        check_val("b2b_sum", sum, 8'h03);
        check_val("b2b_gap", 32'((last_done_t - prev_done_t) / PERIOD), 9);
        idle_check();

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, -1);
        check_val("sub1_sum", sum, 8'hFE);
        check_val("sub1_cout", cout, 0);
        run_op(8'h07, 8'h05, 1'b1, 1'b1, -1);
        check_val("sub2_sum", sum, 8'h02);
        check_val("sub2_cout", cout, 1);
`endif

        // Random operations, some back-to-back, some with stray starts during RUN.
        for (int n = 0; n < 30; n++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            stream(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1, -1);
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller sitting directly upstream of the team's gate-level full-adder cell (sum = a^b^c, carry = ab+ac+bc, with inertial gate delays).
- Accepts two WIDTH-bit operands, streams them LSB-first into the cell, registers the cell's carry back into its carry-in each cycle, and assembles the sum word.
- Reports done with a WIDTH-bit sum and carry-out.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; operands sampled when accepted.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- sub  input  1  subtract request; present only with SERIAL_ADD_SUB_EN.
- fa_a  output  1  bit to full-adder cell input a.
- fa_b  output  1  bit to full-adder cell input b.
- fa_cin  output  1  carry to full-adder cell input c.
- fa_sum  input  1  full-adder cell sum (Y0).
- fa_carry  input  1  full-adder cell carry (Y1).
- busy  output  1  high while streaming bits.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result word, held until the next accepted start.
- cout  output  1  final carry, held with sum.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n low at a rising edge):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - fa_a = 0, fa_b = 0, fa_cin = 0.
  - Internal shift registers and counter = 0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Registers: A_sh, B_sh, S_sh (each WIDTH bits), carry (1 bit), cnt (clog2(WIDTH) bits).
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 is accepted: A_sh <= a, B_sh <= b, carry <= cin, cnt <= 0, state -> RUN.
  - sum and cout retain their previous values until the first RUN edge.
- RUN, each edge:
  - S_sh <= {fa_sum, S_sh[WIDTH-1:1]}.
  - carry <= fa_carry.
  - A_sh and B_sh shift right by one, filling 0.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1 at the edge: sum <= {fa_sum, S_sh[WIDTH-1:1]}, cout <= fa_carry, state -> DONE.
- DONE:
  - done = 1 for exactly one cycle, then state -> IDLE.
  - start = 1 in DONE is accepted exactly as in IDLE, giving back-to-back operation (state -> RUN, done still pulses this cycle).
- start while in RUN is ignored; operands are not resampled.
- Cell drive:
  - fa_a = A_sh[0], fa_b = B_sh[0], fa_cin = carry while in RUN.
  - All three are forced to 0 outside RUN.
  - All are registered-bit derived; no combinational path from the start/a/b inputs.
- Status: busy = (state == RUN), registered.
- Latency: start accepted at edge k gives WIDTH RUN edges (k+1..k+WIDTH); done is high in the cycle after edge k+WIDTH.
- Throughput: one operation per WIDTH+1 cycles back-to-back.
- Timing: the clock period must exceed the cell's worst-case propagation (bench uses period 100 time units against roughly 40-unit worst-case gate delay). fa_sum and fa_carry are sampled only at rising edges.
- Arithmetic: modulo 2^WIDTH sum, with carry-out. No overflow flag.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - sub port exists and is sampled at start acceptance.
  - sub = 1 loads B_sh <= ~b and carry <= 1 (cin ignored), producing a - b.
  - cout = 1 means no borrow.
  - sub = 0 behaves as plain add.
- Undefined:
  - sub port is absent.
  - Block always adds using cin.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0, start at edge k -> busy high edges k+1..k+8, done pulse after edge k+8, sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
- Start a=0x12, b=0x34; assert start again with a=0xFF at the 3rd RUN cycle -> ignored; result sum=0x46, cout=0, exactly one done pulse.
- Start a=0x80, b=0x80; drive rst_n low at the 4th RUN edge -> next edge all outputs 0, state IDLE, no done; a new start after release yields sum=0x00, cout=1.
- Start a second operation in the done cycle with a=0x01, b=0x02 -> first result held until its first RUN edge, second done pulse exactly 9 cycles after the first, sum=0x03.
- With SERIAL_ADD_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; sub=1, a=0x07, b=0x05 -> sum=0x02, cout=1.
